// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: fetches over req/valid and decodes addi/bne into datapath control (RETIRE_COUNT_EN adds retire_count)
module fetch_decode_unit #(
    parameter int Address_Width = 5,
    parameter int Data_Width = 32,
    parameter int PC_Width = 32,
    parameter logic [PC_Width-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [PC_Width-1:0]      imem_addr,
    input  logic                     imem_valid,
    input  logic [Data_Width-1:0]    imem_rdata,
    input  logic                     eq,
    output logic [Address_Width-1:0] rs1,
    output logic [Address_Width-1:0] rs2,
    output logic [Address_Width-1:0] rd,
    output logic [Data_Width-1:0]    ImmOp,
    output logic                     ALUsrc,
    output logic                     ALU_ctrl,
    output logic                     en,
    output logic                     issue_valid,
    output logic [PC_Width-1:0]      pc,
    output logic                     illegal,
`ifdef RETIRE_COUNT_EN
    output logic [31:0]              retire_count,
`endif
    output logic                     halted
);
    typedef enum logic [1:0] {REQ, ISSUE, HALT} state_t;
    state_t state_q, state_d;
    logic [PC_Width-1:0] pc_q, pc_d;
    logic [Data_Width-1:0] ir_q, ir_d;
    logic illegal_q, illegal_d;
    logic is_addi, is_bne, is_halt;
    logic [Data_Width-1:0] imm_i, imm_b;
    assign is_addi = ir_q[6:0] == 7'b0010011 && ir_q[14:12] == 3'b000;
    assign is_bne = ir_q[6:0] == 7'b1100011 && ir_q[14:12] == 3'b001;
    assign is_halt = ir_q == '0;
    assign imm_i = {{(Data_Width-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_b = {{(Data_Width-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd = ir_q[11:7];
    assign ImmOp = is_bne ? imm_b : imm_i;
    assign ALUsrc = !is_bne;
    assign ALU_ctrl = is_bne;
    // the request drops combinationally so nothing is requested during the reset cycle
    assign imem_req = state_q == REQ && !rst;
    assign imem_addr = pc_q;
    assign issue_valid = state_q == ISSUE;
    assign en = issue_valid && is_addi;
    assign pc = pc_q;
    assign illegal = illegal_q;
    assign halted = state_q == HALT;
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        ir_d = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            REQ: begin
                ir_d = imem_valid ? imem_rdata : ir_q;
                state_d = imem_valid ? ISSUE : REQ;
            end
            ISSUE: begin
                state_d = is_halt ? HALT : REQ;
                pc_d = is_halt ? pc_q : (is_bne && !eq) ? pc_q + PC_Width'($signed(ImmOp)) : pc_q + PC_Width'(4);
                illegal_d = illegal_q | !(is_addi || is_bne || is_halt);
            end
            default: state_d = HALT;
        endcase
    end
`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_q, retire_d;
    assign retire_d = retire_q + {31'd0, issue_valid && (is_addi || is_bne)};
    assign retire_count = retire_q;
    always_ff @(posedge clk) begin
        if (rst) retire_q <= '0;
        else retire_q <= retire_d;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q <= RESET_PC;
            ir_q <= Data_Width'(32'h0000_0013);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            ir_q <= ir_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: random fetch stream checked against an architectural PC/flag model
module tb_fetch_decode_unit;
    logic clk = 0, rst = 1, imem_valid = 0, eq = 0;
    logic [31:0] imem_rdata = '0;
    logic imem_req, ALUsrc, ALU_ctrl, en, issue_valid, illegal, halted;
    logic [31:0] imem_addr, ImmOp, pc;
    logic [4:0] rs1, rs2, rd;
`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif
    int n_checks = 0, n_fail = 0;
    logic [31:0] mpc = '0, mret = '0;
    logic mill = 0;
    always #5 clk = ~clk;
    fetch_decode_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .eq(eq),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .ALUsrc(ALUsrc),
        .ALU_ctrl(ALU_ctrl), .en(en), .issue_valid(issue_valid), .pc(pc),
        .illegal(illegal),
`ifdef RETIRE_COUNT_EN
        .retire_count(retire_count),
`endif
        .halted(halted)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic do_reset(input logic [31:0] junk);
        rst = 1; imem_valid = 1; imem_rdata = junk;
        @(negedge clk);
        check("req_during_rst", 32'(imem_req), 0);
        rst = 0; imem_valid = 0;
        mpc = '0; mill = 0; mret = '0;
        @(negedge clk);
        check("rst_req", 32'(imem_req), 1);
        check("rst_addr", imem_addr, 0);
        check("rst_pc", pc, 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_issue", 32'(issue_valid), 0);
        check("rst_en", 32'(en), 0);
        check("rst_nop_rd", 32'(rd), 0);
        check("rst_nop_imm", ImmOp, 0);
`ifdef RETIRE_COUNT_EN
        check("rst_retire", retire_count, 0);
`endif
    endtask
    task automatic run_instr(input logic [31:0] ins, input int stall, input logic e);
        logic a, b, h;
        logic [12:0] bimm;
        logic [31:0] exp_imm;
        a = ins[6:0] == 7'h13 && ins[14:12] == 3'd0;
        b = ins[6:0] == 7'h63 && ins[14:12] == 3'd1;
        h = ins == 32'd0;
        bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        exp_imm = b ? 32'($signed(bimm)) : 32'($signed(ins[31:20]));
        check("req", 32'(imem_req), 1);
        check("addr", imem_addr, mpc);
        check("issue_in_req", 32'(issue_valid), 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_req", 32'(imem_req), 1);
            check("stall_addr", imem_addr, mpc);
            check("stall_issue", 32'(issue_valid), 0);
        end
        imem_valid = 1; imem_rdata = ins;
        @(negedge clk);
        imem_valid = 1'($urandom_range(0, 1)); imem_rdata = $urandom; eq = e;
        check("issue_valid", 32'(issue_valid), 1);
        check("rs1", 32'(rs1), 32'(ins[19:15]));
        check("rs2", 32'(rs2), 32'(ins[24:20]));
        check("rd", 32'(rd), 32'(ins[11:7]));
        check("en", 32'(en), 32'(a));
        if (a || b) begin
            check("imm", ImmOp, exp_imm);
            check("alusrc", 32'(ALUsrc), 32'(a));
            check("aluctrl", 32'(ALU_ctrl), 32'(b));
        end
        @(negedge clk);
        imem_valid = 0;
        if (h) begin
            for (int i = 0; i < 3; i++) begin
                check("halted", 32'(halted), 1);
                check("halt_req", 32'(imem_req), 0);
                check("halt_pc", pc, mpc);
                check("halt_issue", 32'(issue_valid), 0);
                imem_valid = 1; imem_rdata = 32'h00500093;
                @(negedge clk);
                imem_valid = 0;
            end
        end else begin
            mpc = (b && !e) ? mpc + exp_imm : mpc + 4;
            mill = mill | !(a || b);
            if (a || b) mret = mret + 1;
            check("pc", pc, mpc);
            check("illegal", 32'(illegal), 32'(mill));
            check("not_halted", 32'(halted), 0);
`ifdef RETIRE_COUNT_EN
            check("retire", retire_count, mret);
`endif
        end
    endtask
    function automatic logic [31:0] rand_instr();
        int r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        w = $urandom;
        if (r < 5) return {w[31:15], 3'b000, w[11:7], 7'b0010011};
        if (r < 8) return {w[31:15], 3'b001, w[11:7], 7'b1100011};
        if (r == 8) return {w[31:7], 7'b0110011};
        return {w[31:15], 3'b010, w[11:7], 7'b0010011};
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        @(negedge clk);
        do_reset(32'h00500093);
        run_instr(32'h00500093, 0, 0);
        run_instr(32'h00100113, 0, 0);
        run_instr(32'hFE209CE3, 0, 0);
        run_instr(32'h00500093, 0, 0);
        run_instr(32'h00100113, 0, 1);
        run_instr(32'hFE209CE3, 0, 1);
        run_instr(32'h00500093, 3, 0);
        run_instr(32'h00002003, 1, 0);
        run_instr(32'h00700193, 0, 0);
        run_instr(32'h00000000, 2, 0);
        do_reset(32'h00500093);
        run_instr(32'h00500093, 0, 0);
        run_instr(32'h00500093, 0, 0);
        check("pc_before_rst", pc, 8);
        do_reset(32'h00500093);
        check("post_rst_issue", 32'(issue_valid), 0);
        for (int i = 0; i < 80; i++) begin
            if (i % 25 == 24) begin
                run_instr(32'h00000000, $urandom_range(0, 2), 0);
                do_reset($urandom);
            end else begin
                run_instr(rand_instr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
